// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage and in-order fetch queue feeding decode.
// Optional FETCH_PERF_EN enables the bundle/stall performance counters.
module fetch_unit #(
  parameter int unsigned FETCH_W  = 2,
  parameter int unsigned FQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [FETCH_W-1:0][31:0] imem_resp_data,
  output logic [FETCH_W-1:0]       instr_valid,
  output logic [FETCH_W-1:0][31:0] instr,
  output logic [FETCH_W-1:0][31:0] pc,
  input  logic                     decode_ready,
  input  logic                     flush_pipeline,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              perf_bundles,
  output logic [31:0]              perf_stall_cycles
);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] BYTES = 32'(FETCH_W * 4);
  localparam logic [31:0] ALIGN = ~(BYTES - 32'd1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

  function automatic logic [FETCH_W-1:0] lane_mask(input logic [31:0] a);
    int off;
    off = int'((a >> 2) & 32'(FETCH_W - 1));
    for (int i = 0; i < FETCH_W; i++) lane_mask[i] = (i >= off);
  endfunction

  logic [FETCH_W-1:0][31:0] fq_data [FQ_DEPTH];
  logic [31:0]              fq_addr [FQ_DEPTH];
  logic [FETCH_W-1:0]       fq_mask [FQ_DEPTH];

  logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]      count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [FETCH_W-1:0] first_mask_q, first_mask_d, resp_mask_q, resp_mask_d;
  logic               fire, drop, push, pop, empty;

  assign empty          = count_q == '0;
  assign imem_req_addr  = fetch_pc_q & ALIGN;
  assign imem_req_valid = reset && !flush_pipeline && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W);
  assign fire           = imem_req_valid && imem_req_ready;
  assign drop           = imem_resp_valid && (flush_pipeline || drop_q != '0);
  assign push           = imem_resp_valid && !drop;
  assign pop            = !flush_pipeline && decode_ready && !empty;

  // Responses return in order, so the address/mask of the next kept response
  // is tracked on the response side instead of carrying a tag per request.
  always_comb begin
    outst_d      = outst_q + CW'(fire) - CW'(imem_resp_valid);
    drop_d       = flush_pipeline ? outst_d : drop_q - CW'(imem_resp_valid && drop_q != '0);
    count_d      = flush_pipeline ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d         = flush_pipeline ? '0 : wr_q + PW'(push);
    rd_d         = flush_pipeline ? '0 : rd_q + PW'(pop);
    fetch_pc_d   = flush_pipeline ? redirect_pc : fire ? imem_req_addr + BYTES : fetch_pc_q;
    first_mask_d = flush_pipeline ? lane_mask(redirect_pc) : fire ? '1 : first_mask_q;
    resp_pc_d    = flush_pipeline ? redirect_pc & ALIGN : push ? resp_pc_q + BYTES : resp_pc_q;
    resp_mask_d  = flush_pipeline ? lane_mask(redirect_pc) : push ? '1 : resp_mask_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      fetch_pc_q   <= RESET_PC;
      first_mask_q <= '1;
      resp_pc_q    <= RESET_PC & ALIGN;
      resp_mask_q  <= '1;
    end else begin
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      fetch_pc_q   <= fetch_pc_d;
      first_mask_q <= first_mask_d;
      resp_pc_q    <= resp_pc_d;
      resp_mask_q  <= resp_mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_data[wr_q] <= imem_resp_data;
      fq_addr[wr_q] <= resp_pc_q;
      fq_mask[wr_q] <= resp_mask_q;
    end
  end

  always_comb begin
    instr_valid = empty ? '0 : fq_mask[rd_q];
    instr       = empty ? '0 : fq_data[rd_q];
    for (int i = 0; i < FETCH_W; i++) pc[i] = empty ? '0 : fq_addr[rd_q] + 32'(4 * i);
  end

  fq_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count_q == CW'(FQ_DEPTH)));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_bundles_q, perf_bundles_d, perf_stall_q, perf_stall_d;
  always_comb begin
    perf_bundles_d = perf_bundles_q + 32'(pop && perf_bundles_q != '1);
    perf_stall_d   = perf_stall_q + 32'(empty && perf_stall_q != '1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bundles_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_bundles_q <= perf_bundles_d;
      perf_stall_q   <= perf_stall_d;
    end
  end
  assign perf_bundles      = perf_bundles_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_bundles      = '0;
  assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against an in-order memory model
// and an expected sequential decode stream restarted at every redirect.
module tb_fetch_unit;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;

  logic            imem_req_valid, imem_req_ready = 0;
  logic [31:0]     imem_req_addr;
  logic            imem_resp_valid = 0;
  logic [1:0][31:0] imem_resp_data = '0;
  logic [1:0]      instr_valid;
  logic [1:0][31:0] instr, pc;
  logic            decode_ready = 0, flush_pipeline = 0;
  logic [31:0]     redirect_pc = '0, perf_bundles, perf_stall_cycles;

  fetch_unit #(.FETCH_W(2), .FQ_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .decode_ready(decode_ready), .flush_pipeline(flush_pipeline), .redirect_pc(redirect_pc),
    .perf_bundles(perf_bundles), .perf_stall_cycles(perf_stall_cycles)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Lanes before the redirect target's word slot are invalid in the first bundle.
  function automatic logic [1:0] first_lanes(input logic [31:0] a);
    return ((a >> 2) % 2 == 1) ? 2'b10 : 2'b11;
  endfunction

  logic [31:0] mq_addr[$];
  int          mq_due[$], mq_ep[$];
  int          cyc = 0, epoch = 0, lat = 1, tbq = 0;
  int          nfire = 0, npops = 0, nstall = 0;
  int          first_fire = -1, first_vld = -1;
  logic [63:0] first_pc = '0;
  logic [1:0]  first_vm = '0, exp_mask = 2'b11;
  logic [31:0] req_pc = 32'h0, exp_pc = 32'h0;
  logic        prev_flush = 0;

  task automatic step();
    logic fire, pop, acc;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data  = {word_at(mq_addr[0] + 32'd4), word_at(mq_addr[0])};
    end else begin
      imem_resp_valid = 0;
      imem_resp_data  = {$urandom, $urandom};
    end
    #1;
    check("req_valid", 64'(imem_req_valid), 64'(!flush_pipeline && (tbq + mq_addr.size() < 8)));
    if (imem_req_valid) check("req_addr", 64'(imem_req_addr), 64'(req_pc));
    if (prev_flush) check("flush_clr", 64'(instr_valid), 64'd0);
    if (instr_valid != 0) begin
      check("lane_mask", 64'(instr_valid), 64'(exp_mask));
      check("pc", pc, {exp_pc + 32'd4, exp_pc});
      check("instr", instr, {word_at(exp_pc + 32'd4), word_at(exp_pc)});
      if (first_vld < 0) begin
        first_vld = cyc;
        first_pc  = pc;
        first_vm  = instr_valid;
      end
    end else check("empty_out", instr | pc, 64'd0);
`ifdef FETCH_PERF_EN
    check("perf_bundles", 64'(perf_bundles), 64'(npops));
    check("perf_stall", 64'(perf_stall_cycles), 64'(nstall));
`else
    check("perf_off", {perf_bundles, perf_stall_cycles}, 64'd0);
`endif
    fire = imem_req_valid && imem_req_ready;
    acc  = 0;
    if (imem_resp_valid) begin
      acc = (mq_ep[0] == epoch) && !flush_pipeline;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      void'(mq_ep.pop_front());
    end
    if (fire) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      mq_ep.push_back(epoch);
      req_pc += 32'd8;
      nfire++;
      if (first_fire < 0) first_fire = cyc;
    end
    pop = decode_ready && instr_valid != 0 && !flush_pipeline;
    if (pop) begin
      npops++;
      exp_pc  += 32'd8;
      exp_mask = 2'b11;
    end
    if (instr_valid == 0) nstall++;
    if (flush_pipeline) begin
      epoch++;
      tbq      = 0;
      exp_pc   = redirect_pc & ~32'h7;
      exp_mask = first_lanes(redirect_pc);
      req_pc   = redirect_pc & ~32'h7;
    end else tbq += int'(acc) - int'(pop);
    prev_flush = flush_pipeline;
    cyc++;
    @(negedge clk);
  endtask

  task automatic flush_to(input logic [31:0] target);
    flush_pipeline = 1;
    redirect_pc    = target;
    step();
    flush_pipeline = 0;
  endtask

  initial begin
    int n0, w;
    repeat (3) @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_instr", instr, 64'd0);

    imem_req_ready = 1;
    decode_ready   = 1;
    lat            = 1;
    reset          = 1;
    repeat (12) step();
    check("t1_latency", 64'(first_vld - first_fire), 64'd2);
    check("t1_pc", first_pc, {32'h4, 32'h0});
    check("t1_mask", 64'(first_vm), 64'h3);

    decode_ready = 0;
    flush_to(32'h200);
    n0 = nfire;
    repeat (20) step();
    check("t2_reqs", 64'(nfire - n0), 64'd8);
    check("t2_hold", 64'(imem_req_valid), 64'd0);
    imem_req_ready = 0;
    decode_ready   = 1;
    n0 = npops;
    repeat (20) step();
    check("t2_drain", 64'(npops - n0), 64'd8);

    imem_req_ready = 1;
    lat = 5;
    flush_to(32'h0);
    w = 0;
    while (mq_addr.size() != 4 && w < 20) begin
      step();
      w++;
    end
    check("t3_outst", 64'(mq_addr.size()), 64'd4);
    first_vld = -1;
    flush_to(32'h104);
    w = 0;
    while (first_vld < 0 && w < 40) begin
      step();
      w++;
    end
    check("t3_pc", first_pc, {32'h104, 32'h100});
    check("t3_mask", 64'(first_vm), 64'h2);

    lat = 3;
    repeat (10) step();
    w = 0;
    while (!(mq_addr.size() > 0 && mq_due[0] <= cyc && instr_valid != 0) && w < 40) begin
      step();
      w++;
    end
    check("t4_found", 64'(w < 40), 64'd1);
    n0 = npops;
    flush_to(32'h40);
    repeat (30) step();
    check("t4_progress", 64'(npops > n0), 64'd1);

    repeat (10000) begin
      imem_req_ready = $urandom_range(0, 3) != 0;
      decode_ready   = $urandom_range(0, 2) != 0;
      lat            = $urandom_range(1, 6);
      flush_pipeline = $urandom_range(0, 63) == 0;
      redirect_pc    = $urandom & 32'h0000_0FFC;
      step();
    end
    flush_pipeline = 0;
    decode_ready   = 1;
    imem_req_ready = 1;
    n0 = npops;
    repeat (30) step();
    check("t5_alive", 64'(npops > n0), 64'd1);

    reset = 0;
    #1;
    check("rst2_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst2_instr_valid", 64'(instr_valid), 64'd0);
    check("rst2_pc", pc, 64'd0);
    check("rst2_perf", {perf_bundles, perf_stall_cycles}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
